// File: rtl/intxn_ctrl_multi.sv
// intxn_ctrl_multi: intersection controller serving NUM_APPROACH side-road
// request channels against one main road. Each raw request is synchronised,
// edge-detected and latched until the next side green serves it. All phase
// timing is counted in prescaled ticks of TICK_DIV clock cycles.
// Optional macro PED_PHASE_EN adds ped_req/walk and an all-red walk interval
// of WALK_T ticks inside AR_SIDE before the side road gets green.

module intxn_ctrl_multi #(
    parameter int NUM_APPROACH = 2,
    parameter int TICK_DIV     = 50000000,
    parameter int MIN_GREEN    = 10,
    parameter int SIDE_GREEN   = 6,
    parameter int YELLOW_T     = 3,
    parameter int ALLRED_T     = 1
`ifdef PED_PHASE_EN
    , parameter int WALK_T     = 5
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_APPROACH-1:0] car_req,
`ifdef PED_PHASE_EN
    input  logic                    ped_req,
    output logic                    walk,
`endif
    output logic [2:0]              main_lights,
    output logic [2:0]              side_lights,
    output logic [NUM_APPROACH-1:0] req_pending,
    output logic [2:0]              phase
);

    typedef enum logic [2:0] {
        AR_MAIN = 3'd0,
        MAIN_G  = 3'd1,
        MAIN_Y  = 3'd2,
        AR_SIDE = 3'd3,
        SIDE_G  = 3'd4,
        SIDE_Y  = 3'd5
    } state_t;

    localparam int MAX_A = (MIN_GREEN > SIDE_GREEN) ? MIN_GREEN : SIDE_GREEN;
    localparam int MAX_B = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`ifdef PED_PHASE_EN
    localparam int MAX_D = (MAX_C > WALK_T) ? MAX_C : WALK_T;
`else
    localparam int MAX_D = MAX_C;
`endif
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int DUR_W  = $clog2(MAX_D + 1);

    // Reject zero or negative timing/channel parameters at elaboration.
    if (NUM_APPROACH < 1 || TICK_DIV < 1 || MIN_GREEN < 1 || SIDE_GREEN < 1 ||
        YELLOW_T < 1 || ALLRED_T < 1) begin : gBadParam
        $error("intxn_ctrl_multi: all parameters must be >= 1");
    end
`ifdef PED_PHASE_EN
    if (WALK_T < 1) begin : gBadWalk
        $error("intxn_ctrl_multi: WALK_T must be >= 1");
    end
`endif

    state_t                  state_q, state_d;
    logic [TICK_W-1:0]       tickCnt_q;
    logic [DUR_W-1:0]        durCnt_q;
    logic [DUR_W-1:0]        durLimit;
    logic [2:0]              mainLights_q, sideLights_q;
    logic [NUM_APPROACH-1:0] reqSync1_q, reqSync2_q, reqPrev_q, reqPending_q;
    logic [NUM_APPROACH-1:0] reqEdge;
    logic                    tickDone, durDone, saturated, restart, anyReq;
    logic                    enterSideG;
`ifdef PED_PHASE_EN
    logic                    pedSync1_q, pedSync2_q, pedPrev_q, pedPending_q;
    logic                    pedEdge, walk_q, walk_d;
`endif

    function automatic logic [2:0] mainOf(input state_t s);
        case (s)
            MAIN_G:  mainOf = 3'b001;
            MAIN_Y:  mainOf = 3'b010;
            default: mainOf = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] sideOf(input state_t s);
        case (s)
            SIDE_G:  sideOf = 3'b001;
            SIDE_Y:  sideOf = 3'b010;
            default: sideOf = 3'b100;
        endcase
    endfunction

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reqSync1_q <= '0;
            reqSync2_q <= '0;
            reqPrev_q  <= '0;
        end else begin
            reqSync1_q <= car_req;
            reqSync2_q <= reqSync1_q;
            reqPrev_q  <= reqSync2_q;
        end
    end

    assign reqEdge = reqSync2_q & ~reqPrev_q;

`ifdef PED_PHASE_EN
    // Pedestrian button gets the same synchronise-and-edge treatment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pedSync1_q <= 1'b0;
            pedSync2_q <= 1'b0;
            pedPrev_q  <= 1'b0;
        end else begin
            pedSync1_q <= ped_req;
            pedSync2_q <= pedSync1_q;
            pedPrev_q  <= pedSync2_q;
        end
    end

    assign pedEdge = pedSync2_q & ~pedPrev_q;
    assign anyReq  = (|reqPending_q) | pedPending_q;
`else
    assign anyReq  = |reqPending_q;
`endif

    // Tick and duration bookkeeping for the current phase.
    always_comb begin
        durLimit = DUR_W'(1);
        case (state_q)
            AR_MAIN: durLimit = DUR_W'(ALLRED_T);
            MAIN_G:  durLimit = DUR_W'(MIN_GREEN);
            MAIN_Y:  durLimit = DUR_W'(YELLOW_T);
`ifdef PED_PHASE_EN
            AR_SIDE: durLimit = walk_q ? DUR_W'(WALK_T) : DUR_W'(ALLRED_T);
`else
            AR_SIDE: durLimit = DUR_W'(ALLRED_T);
`endif
            SIDE_G:  durLimit = DUR_W'(SIDE_GREEN);
            SIDE_Y:  durLimit = DUR_W'(YELLOW_T);
            default: durLimit = DUR_W'(1);
        endcase
    end

    assign tickDone  = (tickCnt_q == TICK_W'(TICK_DIV - 1));
    assign durDone   = tickDone && (durCnt_q == durLimit - DUR_W'(1));
    assign saturated = (durCnt_q == durLimit);

    // Next-phase decision; restart marks every phase entry so timing begins at zero.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
`ifdef PED_PHASE_EN
        walk_d  = walk_q;
`endif
        case (state_q)
            AR_MAIN: if (durDone) begin
                state_d = MAIN_G;
                restart = 1'b1;
            end
            MAIN_G: if ((saturated || durDone) && anyReq) begin
                state_d = MAIN_Y;
                restart = 1'b1;
            end
            MAIN_Y: if (durDone) begin
                state_d = AR_SIDE;
                restart = 1'b1;
            end
            AR_SIDE: if (durDone) begin
                restart = 1'b1;
`ifdef PED_PHASE_EN
                if (!walk_q && pedPending_q) begin
                    walk_d = 1'b1;
                end else begin
                    walk_d  = 1'b0;
                    state_d = SIDE_G;
                end
`else
                state_d = SIDE_G;
`endif
            end
            SIDE_G: if (durDone) begin
                state_d = SIDE_Y;
                restart = 1'b1;
            end
            SIDE_Y: if (durDone) begin
                state_d = AR_MAIN;
                restart = 1'b1;
            end
            default: begin
                state_d = AR_MAIN;
                restart = 1'b1;
            end
        endcase
    end

    // Phase register, counters and registered lights (lights follow the next phase).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= AR_MAIN;
            tickCnt_q    <= '0;
            durCnt_q     <= '0;
            mainLights_q <= 3'b100;
            sideLights_q <= 3'b100;
        end else begin
            state_q      <= state_d;
            mainLights_q <= mainOf(state_d);
            sideLights_q <= sideOf(state_d);
            if (restart) begin
                tickCnt_q <= '0;
                durCnt_q  <= '0;
            end else if (saturated) begin
                tickCnt_q <= '0;
            end else if (tickDone) begin
                tickCnt_q <= '0;
                durCnt_q  <= durCnt_q + DUR_W'(1);
            end else begin
                tickCnt_q <= tickCnt_q + TICK_W'(1);
            end
        end
    end

    assign enterSideG = (state_d == SIDE_G) && (state_q != SIDE_G);

    // Latch request edges; side-green entry clears them and edges during side green are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reqPending_q <= '0;
        end else if (enterSideG) begin
            reqPending_q <= '0;
        end else if (state_q != SIDE_G) begin
            reqPending_q <= reqPending_q | reqEdge;
        end
    end

`ifdef PED_PHASE_EN
    // Pedestrian request latch and walk indicator; the latch clears when walk starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pedPending_q <= 1'b0;
            walk_q       <= 1'b0;
        end else begin
            walk_q <= walk_d;
            if (walk_d && !walk_q) begin
                pedPending_q <= 1'b0;
            end else begin
                pedPending_q <= pedPending_q | pedEdge;
            end
        end
    end

    assign walk = walk_q;
`endif

    assign main_lights = mainLights_q;
    assign side_lights = sideLights_q;
    assign req_pending = reqPending_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_intxn_ctrl_multi.sv
// tb_intxn_ctrl_multi: directed checks of the intersection controller with a
// short tick (TICK_DIV=4) so whole phase sequences fit in a few hundred cycles.

module tb_intxn_ctrl_multi;

    localparam logic [2:0] P_AR_MAIN = 3'd0;
    localparam logic [2:0] P_MAIN_G  = 3'd1;
    localparam logic [2:0] P_MAIN_Y  = 3'd2;
    localparam logic [2:0] P_AR_SIDE = 3'd3;
    localparam logic [2:0] P_SIDE_G  = 3'd4;
    localparam logic [2:0] P_SIDE_Y  = 3'd5;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] car_req = 2'b00;
    logic [2:0] main_lights, side_lights, phase;
    logic [1:0] req_pending;
`ifdef PED_PHASE_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    intxn_ctrl_multi #(
        .NUM_APPROACH(2),
        .TICK_DIV(4),
        .MIN_GREEN(3),
        .SIDE_GREEN(4),
        .YELLOW_T(2),
        .ALLRED_T(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .car_req(car_req),
`ifdef PED_PHASE_EN
        .ped_req(ped_req),
        .walk(walk),
`endif
        .main_lights(main_lights),
        .side_lights(side_lights),
        .req_pending(req_pending),
        .phase(phase)
    );

    // Counts consecutive negedge samples spent in phase p, bounded by limit.
    task automatic measure(input logic [2:0] p, input int limit, output int n);
        n = 0;
        while (phase === p && n < limit) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if (phase !== P_AR_MAIN || main_lights !== 3'b100 || side_lights !== 3'b100 || req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got phase=%0d main=%b side=%b req=%b, expected 0 100 100 00",
                     phase, main_lights, side_lights, req_pending);
        end
        reset = 1'b0;
        measure(P_AR_MAIN, 50, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("[TB] FAIL ar_main_len: got %0d cycles, expected 4", n);
        end
        vectors++;
        if (phase !== P_MAIN_G || main_lights !== 3'b001 || side_lights !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL main_g_entry: got phase=%0d main=%b side=%b, expected 1 001 100",
                     phase, main_lights, side_lights);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (phase !== P_MAIN_G || main_lights !== 3'b001 || side_lights !== 3'b100 || req_pending !== 2'b00)
                bad++;
            @(negedge clock);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL main_g_hold: got %0d bad cycles of 200, expected 0", bad);
        end
    endtask

    task automatic test_single_request();
        int n;
        logic [2:0] seqP [5];
        int         seqL [5];
        logic [2:0] seqM [5];
        logic [2:0] seqS [5];
        seqP = '{P_MAIN_Y, P_AR_SIDE, P_SIDE_G, P_SIDE_Y, P_AR_MAIN};
        seqL = '{8, 4, 16, 8, 4};
        seqM = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        seqS = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        car_req = 2'b01;
        @(negedge clock);
        car_req = 2'b00;
        vectors++;
        if (req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL req_lat_1: got %b, expected 00", req_pending);
        end
        @(negedge clock);
        vectors++;
        if (req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL req_lat_2: got %b, expected 00", req_pending);
        end
        @(negedge clock);
        vectors++;
        if (req_pending !== 2'b01 || phase !== P_MAIN_G) begin
            miscompares++;
            $display("[TB] FAIL req_lat_3: got req=%b phase=%0d, expected 01 1", req_pending, phase);
        end
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (phase !== seqP[k] || main_lights !== seqM[k] || side_lights !== seqS[k]) begin
                miscompares++;
                $display("[TB] FAIL seq_entry_%0d: got phase=%0d main=%b side=%b, expected %0d %b %b",
                         k, phase, main_lights, side_lights, seqP[k], seqM[k], seqS[k]);
            end
            if (seqP[k] == P_SIDE_G) begin
                vectors++;
                if (req_pending !== 2'b00) begin
                    miscompares++;
                    $display("[TB] FAIL side_g_clear: got %b, expected 00", req_pending);
                end
            end
            measure(seqP[k], 100, n);
            vectors++;
            if (n !== seqL[k]) begin
                miscompares++;
                $display("[TB] FAIL seq_len_%0d: got %0d cycles, expected %0d", k, n, seqL[k]);
            end
        end
        vectors++;
        if (phase !== P_MAIN_G) begin
            miscompares++;
            $display("[TB] FAIL return_main_g: got phase=%0d, expected 1", phase);
        end
    endtask

    task automatic test_min_green();
        int n;
        logic [2:0] seqP [5];
        int         seqL [5];
        seqP = '{P_MAIN_Y, P_AR_SIDE, P_SIDE_G, P_SIDE_Y, P_AR_MAIN};
        seqL = '{8, 4, 16, 8, 4};
        n = 0;
        while (phase === P_MAIN_G && n < 100) begin
            if (n == 2) car_req = 2'b10;
            if (n == 4) car_req = 2'b00;
            n++;
            @(negedge clock);
        end
        vectors++;
        if (n !== 12) begin
            miscompares++;
            $display("[TB] FAIL min_green_len: got %0d cycles, expected 12", n);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (phase !== seqP[k]) begin
                miscompares++;
                $display("[TB] FAIL mg_seq_%0d: got phase=%0d, expected %0d", k, phase, seqP[k]);
            end
            measure(seqP[k], 100, n);
            vectors++;
            if (n !== seqL[k]) begin
                miscompares++;
                $display("[TB] FAIL mg_len_%0d: got %0d cycles, expected %0d", k, n, seqL[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        repeat (20) @(negedge clock);
        car_req = 2'b11;
        @(negedge clock);
        car_req = 2'b00;
        repeat (2) @(negedge clock);
        vectors++;
        if (req_pending !== 2'b11 || phase !== P_MAIN_G) begin
            miscompares++;
            $display("[TB] FAIL both_latched: got req=%b phase=%0d, expected 11 1", req_pending, phase);
        end
        @(negedge clock);
        measure(P_MAIN_Y, 100, n);
        measure(P_AR_SIDE, 100, n);
        vectors++;
        if (phase !== P_SIDE_G || req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL both_cleared: got phase=%0d req=%b, expected 4 00", phase, req_pending);
        end
        n = 0;
        while (phase === P_SIDE_G && n < 100) begin
            if (n == 3) car_req = 2'b10;
            if (n == 4) car_req = 2'b00;
            n++;
            @(negedge clock);
        end
        vectors++;
        if (n !== 16 || phase !== P_SIDE_Y || req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL side_g_discard: got len=%0d phase=%0d req=%b, expected 16 5 00", n, phase, req_pending);
        end
        n = 0;
        while (phase === P_SIDE_Y && n < 100) begin
            if (n == 1) car_req = 2'b10;
            if (n == 2) car_req = 2'b00;
            n++;
            @(negedge clock);
        end
        vectors++;
        if (n !== 8 || phase !== P_AR_MAIN || req_pending !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL side_y_latch: got len=%0d phase=%0d req=%b, expected 8 0 10", n, phase, req_pending);
        end
        measure(P_AR_MAIN, 100, n);
        measure(P_MAIN_G, 100, n);
        vectors++;
        if (n !== 12 || phase !== P_MAIN_Y) begin
            miscompares++;
            $display("[TB] FAIL second_side: got main_g len=%0d phase=%0d, expected 12 2", n, phase);
        end
        measure(P_MAIN_Y, 100, n);
        measure(P_AR_SIDE, 100, n);
    endtask

    task automatic test_reset_mid();
        int n;
        vectors++;
        if (phase !== P_SIDE_G || side_lights !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got phase=%0d side=%b, expected 4 001", phase, side_lights);
        end
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (phase !== P_AR_MAIN || main_lights !== 3'b100 || side_lights !== 3'b100 || req_pending !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got phase=%0d main=%b side=%b req=%b, expected 0 100 100 00",
                     phase, main_lights, side_lights, req_pending);
        end
        @(negedge clock);
        reset = 1'b0;
        measure(P_AR_MAIN, 50, n);
        vectors++;
        if (n !== 4 || phase !== P_MAIN_G || main_lights !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL resume: got ar_len=%0d phase=%0d main=%b, expected 4 1 001", n, phase, main_lights);
        end
    endtask

`ifdef PED_PHASE_EN
    task automatic test_ped();
        int n;
        int walkCnt;
        int walkBad;
        repeat (20) @(negedge clock);
        ped_req = 1'b1;
        @(negedge clock);
        ped_req = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (phase !== P_MAIN_Y || walk !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ped_exit: got phase=%0d walk=%b, expected 2 0", phase, walk);
        end
        measure(P_MAIN_Y, 100, n);
        n = 0;
        walkCnt = 0;
        walkBad = 0;
        while (phase === P_AR_SIDE && n < 100) begin
            if (walk === 1'b1) walkCnt++;
            if (main_lights !== 3'b100 || side_lights !== 3'b100) walkBad++;
            if (n < 4 && walk !== 1'b0) walkBad++;
            n++;
            @(negedge clock);
        end
        vectors++;
        if (n !== 24 || walkCnt !== 20 || walkBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL walk_interval: got len=%0d walk=%0d bad=%0d, expected 24 20 0", n, walkCnt, walkBad);
        end
        vectors++;
        if (phase !== P_SIDE_G || walk !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL walk_end: got phase=%0d walk=%b, expected 4 0", phase, walk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_request();
        test_min_green();
        test_back_to_back();
        test_reset_mid();
`ifdef PED_PHASE_EN
        test_ped();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intxn_ctrl_multi.md
Name: intxn_ctrl_multi

Overview:
- Parametrised successor to the two-button, one-FSM intersection controller. Accepts NUM_APPROACH independent side-road car requests and synchronises each one.
- Latches each request until it is served. Runs a timed main/side phase sequence with yellow and all-red clearances, all counted in prescaled ticks.
- Sits between the board key/sensor conditioning and the LED light drivers; replaces the fixed-timing controller.

Parameters:
- NUM_APPROACH, 2, number of side-road request channels.
- TICK_DIV, 50000000, clock cycles per timing tick (1 s at 50 MHz).
- MIN_GREEN, 10, minimum main-road green in ticks.
- SIDE_GREEN, 6, side-road green in ticks.
- YELLOW_T, 3, yellow duration in ticks, both roads.
- ALLRED_T, 1, all-red clearance in ticks.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- car_req  in  NUM_APPROACH  raw active-high car present, one bit per side approach; asynchronous to clock.
- main_lights  out  3  {red,yellow,green}, main road.
- side_lights  out  3  {red,yellow,green}, side road.
- req_pending  out  NUM_APPROACH  latched, not-yet-served requests.
- phase  out  3  current state encoding, for debug.

Behaviour:
- Synchronisation: each car_req bit passes through 2 flops, then a rising-edge detector. A raw rise sets the matching req_pending bit exactly 3 cycles later.
- States and encodings:
  - AR_MAIN=0: all red, leads to main green.
  - MAIN_G=1
  - MAIN_Y=2
  - AR_SIDE=3: all red, leads to side green.
  - SIDE_G=4
  - SIDE_Y=5
- Lights per state:
  - MAIN_G: main=001, side=100.
  - MAIN_Y: main=010, side=100.
  - SIDE_G: main=100, side=001.
  - SIDE_Y: main=100, side=010.
  - AR_*: main=100, side=100.
  - Encodings 6 and 7 are never driven. If reached, return to AR_MAIN next cycle.
- Reset (asynchronous assert): state AR_MAIN, main=100, side=100, req_pending=0, phase=0. Tick counter, duration counter and sync flops are all cleared.
- Timing:
  - The tick prescaler restarts at 0 on every state entry.
  - A timed state of D ticks lasts exactly D*TICK_DIV cycles, then transitions.
- Transitions:
  - AR_MAIN (ALLRED_T) -> MAIN_G.
  - MAIN_G: when MIN_GREEN ticks have elapsed, the duration counter saturates. The state then goes to MAIN_Y on the first cycle after saturation on which |req_pending=1. With no request it holds MAIN_G indefinitely.
  - MAIN_Y (YELLOW_T) -> AR_SIDE.
  - AR_SIDE (ALLRED_T) -> SIDE_G.
  - SIDE_G (SIDE_GREEN) -> SIDE_Y.
  - SIDE_Y (YELLOW_T) -> AR_MAIN.
- Request handling:
  - Entering SIDE_G clears all req_pending bits.
  - Request edges arriving while in SIDE_G are discarded; that approach is already being served.
  - Edges arriving in every other state set their bit.
  - A set and a clear in the same cycle (edge on the cycle of SIDE_G entry): the clear wins.
- Simultaneous requests on several channels are OR-combined and served by one side phase.
- A held-high car_req produces only one edge. It is not re-requested after service until it falls and rises again.
- Outputs are registered, with no combinational path from car_req.
- Width rules: counters are sized with $clog2(param+1). All parameters must be >=1, checked at elaboration.
- Reset asserted mid-phase returns the block to AR_MAIN immediately (asynchronously). Nothing is preserved.

Optional Feature:
- Macro: PED_PHASE_EN.
- Defined:
  - Adds input ped_req (1 bit) and output walk (1 bit). ped_req is synchronised and edge-latched like car_req, and feeds an internal ped_pending bit.
  - ped_pending also triggers MAIN_G exit, under the same MIN_GREEN rule.
  - In AR_SIDE, if ped_pending is set, walk=1 for an extra WALK_T (default 5) ticks of all-red before SIDE_G. ped_pending clears at walk start.
  - walk=0 in every other state and at reset.
- Undefined: no ped ports, no walk phase; behaviour exactly as above.

Test Plan:
- Bench parameters: TICK_DIV=4, MIN_GREEN=3, SIDE_GREEN=4, YELLOW_T=2, ALLRED_T=1, NUM_APPROACH=2.
- Reset release, no requests -> AR_MAIN for 4 cycles, then MAIN_G held for 200 cycles; side=100 throughout, req_pending=00.
- car_req[0] pulse while MAIN_G has been saturated for 10+ cycles -> req_pending=01 3 cycles after the rise. Then MAIN_Y for 8 cycles, AR_SIDE for 4, SIDE_G for 16 with req_pending=00 on entry, SIDE_Y for 8, AR_MAIN for 4, MAIN_G.
- car_req[1] rises 2 cycles after MAIN_G entry -> MAIN_G still lasts exactly 12 cycles (MIN_GREEN enforced) before MAIN_Y.
- car_req[0] and [1] rise on the same cycle -> req_pending=11, exactly one side phase, both cleared on SIDE_G entry. A car_req[1] rise during SIDE_G leaves req_pending=00 afterwards; a rise during SIDE_Y sets 10 and forces a second side phase after MIN_GREEN.
- reset asserted during SIDE_G -> same cycle (asynchronously) main=100, side=100, phase=0, req_pending=00. After release the normal AR_MAIN→MAIN_G sequence resumes.
- PED_PHASE_EN defined, ped_req pulse in MAIN_G -> walk=1 for 20 cycles inside AR_SIDE, with both roads red; walk=0 elsewhere.
